// File: rtl/fp32_booth_mul.sv
// fp32_booth_mul: sequential IEEE-754 binary32 multiplier.
// Significands are multiplied by an iterative radix-4 Booth datapath, one
// recoded digit per cycle (13 digits). Subnormal inputs flush to zero and
// no subnormal results are produced.
// Optional feature macro: FP32_MUL_RNE_EN selects round-to-nearest-even;
// when undefined the product is truncated and no rounding adder exists.
module fp32_booth_mul (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE, UNPACK, ITER, PACK} state_t;

  state_t             state, state_nxt;
  logic [3:0]         iter_cnt;
  logic [31:0]        a_q, b_q;
  logic               sign_q, nan_q, inf_q, zero_q;
  logic signed [9:0]  exp_q;
  logic [23:0]        mcand;
  logic [26:0]        mplr;
  logic signed [49:0] acc;

  logic [22:0]        mant, mant_f;
  logic signed [9:0]  e_n, e_r;
  logic [31:0]        res_nxt;
  logic               ovf_nxt, unf_nxt, inv_nxt;
  logic               acc_unused;

  // Booth partial product for one digit, pre-aligned to the accumulator top.
  function automatic logic signed [49:0] booth_pp(input logic [2:0] dig,
                                                  input logic [23:0] m);
    logic signed [25:0] m1, m2, pp;
    m1 = $signed({2'b00, m});
    m2 = $signed({1'b0, m, 1'b0});
    case (dig)
      3'b001, 3'b010: pp = m1;
      3'b011:         pp = m2;
      3'b100:         pp = -m2;
      3'b101, 3'b110: pp = -m1;
      default:        pp = 26'sd0;
    endcase
    return $signed({pp, 24'd0});
  endfunction

`ifdef FP32_MUL_RNE_EN
  // Round-to-nearest-even increment decision.
  function automatic logic round_up(input logic lsb, input logic guard,
                                    input logic sticky);
    return guard & (sticky | lsb);
  endfunction
`endif

  assign busy = (state != IDLE);

  // Top bits are sign extension; low bits only feed rounding when enabled.
  assign acc_unused = ^{acc[49:48], acc[22:0]};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = ITER;
      ITER:    if (iter_cnt == 4'd12) state_nxt = PACK;
      PACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Booth digit counter.
  always_ff @(posedge clk) begin
    if (rst)                 iter_cnt <= 4'd0;
    else if (state == UNPACK) iter_cnt <= 4'd0;
    else if (state == ITER)   iter_cnt <= iter_cnt + 4'd1;
  end

  // Datapath: operand capture, unpack/classify, Booth iteration.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_q <= a;
      b_q <= b;
    end
    if (state == UNPACK) begin
      sign_q <= a_q[31] ^ b_q[31];
      nan_q  <= (&a_q[30:23] && |a_q[22:0]) || (&b_q[30:23] && |b_q[22:0]);
      inf_q  <= (&a_q[30:23] && ~|a_q[22:0]) || (&b_q[30:23] && ~|b_q[22:0]);
      zero_q <= (~|a_q[30:23]) || (~|b_q[30:23]);
      exp_q  <= $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
                - 10'sd127;
      mcand  <= {1'b1, a_q[22:0]};
      mplr   <= {2'b00, 1'b1, b_q[22:0], 1'b0};
      acc    <= 50'sd0;
    end
    if (state == ITER) begin
      acc  <= (acc >>> 2) + booth_pp(mplr[2:0], mcand);
      mplr <= mplr >> 2;
    end
  end

  // Normalize, round and resolve special cases for the PACK cycle.
  always_comb begin
    mant    = acc[45:23];
    e_n     = exp_q;
    mant_f  = mant;
    e_r     = e_n;
    res_nxt = 32'd0;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    inv_nxt = 1'b0;
    if (acc[47]) begin
      mant = acc[46:24];
      e_n  = exp_q + 10'sd1;
    end
`ifdef FP32_MUL_RNE_EN
    begin
      logic        guard, sticky;
      logic [23:0] mant_r;
      guard  = acc[47] ? acc[23] : acc[22];
      sticky = acc[47] ? |acc[22:0] : |acc[21:0];
      mant_r = {1'b0, mant} + {23'd0, round_up(mant[0], guard, sticky)};
      mant_f = mant_r[22:0];
      e_r    = mant_r[23] ? e_n + 10'sd1 : e_n;
    end
`else
    mant_f = mant;
    e_r    = e_n;
`endif
    if (nan_q || (inf_q && zero_q)) begin
      res_nxt = 32'h7FC00000;
      inv_nxt = 1'b1;
    end else if (inf_q) begin
      res_nxt = {sign_q, 8'hFF, 23'd0};
    end else if (zero_q) begin
      res_nxt = {sign_q, 31'd0};
    end else if (e_r >= 10'sd255) begin
      res_nxt = {sign_q, 8'hFF, 23'd0};
      ovf_nxt = 1'b1;
    end else if (e_r <= 10'sd0) begin
      res_nxt = {sign_q, 31'd0};
      unf_nxt = 1'b1;
    end else begin
      res_nxt = {sign_q, e_r[7:0], mant_f};
    end
  end

  // Output registers: done pulse, held result and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= (state == PACK);
      if (state == PACK) begin
        result    <= res_nxt;
        overflow  <= ovf_nxt;
        underflow <= unf_nxt;
        invalid   <= inv_nxt;
      end else if (state == IDLE && start) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
        invalid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp32_booth_mul.sv
// Scoreboard bench for fp32_booth_mul: a driver pushes expected responses,
// a monitor pops them on every done pulse. Expected values come from
// constants or an integer-arithmetic reference model.
module tb_fp32_booth_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, done, overflow, underflow, invalid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    logic        ovf, unf, inv;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fp32_booth_mul dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic o,
                              input logic u, input logic i);
    exp_t e;
    e.res = r; e.ovf = o; e.unf = u; e.inv = i; e.done_cyc = 0;
    return e;
  endfunction

  // Reference: exact integer product of significands, then normalize/round.
  function automatic exp_t ref_mul(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    int ex, ey, e, sh;
    logic s;
    bit xz, xi, xn, yz, yi, yn;
    longint unsigned p, keep;
`ifdef FP32_MUL_RNE_EN
    longint unsigned rem, half;
`endif
    r = mk(32'd0, 1'b0, 1'b0, 1'b0);
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);   yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xi && yz) || (xz && yi)) begin
      r.res = 32'h7FC00000; r.inv = 1'b1;
    end else if (xi || yi) begin
      r.res = {s, 8'hFF, 23'd0};
    end else if (xz || yz) begin
      r.res = {s, 31'd0};
    end else begin
      p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
      e = ex + ey - 127;
      if (p >= (64'd1 << 47)) begin e = e + 1; sh = 24; end
      else sh = 23;
      keep = p >> sh;
`ifdef FP32_MUL_RNE_EN
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (keep % 2 == 1))) keep = keep + 1;
      if (keep == (64'd1 << 24)) begin keep = 64'd1 << 23; e = e + 1; end
`endif
      if (e >= 255) begin
        r.res = {s, 8'hFF, 23'd0}; r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.res = {s, 31'd0}; r.unf = 1'b1;
      end else begin
        r.res = {s, 8'(e), 23'(keep)};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] gen_op();
    logic       s;
    logic [22:0] m;
    s = 1'($urandom);
    m = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       return {s, 8'h00, m};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, m | 23'd1};
      3:       return {s, 8'($urandom_range(190, 254)), m};
      4:       return {s, 8'($urandom_range(1, 60)), m};
      5:       return {s, 8'($urandom_range(100, 154)), 23'h7FFFFF};
      default: return {s, 8'($urandom_range(100, 154)), m};
    endcase
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y,
                       input exp_t e, input bit noise);
    int n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("busy_wait_timeout", {31'd0, busy}, 32'd0);
    start = 1'b1; a = x; b = y;
    e.done_cyc = cyc + 1 + 15;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    if (noise) begin
      @(negedge clk);
      start = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got result %h with empty scoreboard", result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result",    result, e.res);
        chk("overflow",  {31'd0, overflow},  {31'd0, e.ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, e.unf});
        chk("invalid",   {31'd0, invalid},   {31'd0, e.inv});
        chk("latency",   32'(cyc), 32'(e.done_cyc));
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, done_cnt;
    logic [31:0] x, y;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy",   {31'd0, busy}, 32'd0);
    chk("reset_done",   {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags",  {29'd0, overflow, underflow, invalid}, 32'd0);

    // Directed cases with fixed expected values.
    issue(32'h3F800000, 32'h3F800000, mk(32'h3F800000, 0, 0, 0), 1'b0);
    issue(32'h3FC00000, 32'h3FE00000, mk(32'h40280000, 0, 0, 0), 1'b0);
    issue(32'h3F800000, 32'h3D0D8EC9, mk(32'h3D0D8EC9, 0, 0, 0), 1'b1);
    issue(32'h7FE00000, 32'h7FC00000, mk(32'h7FC00000, 0, 0, 1), 1'b0);
    issue(32'h7F800000, 32'h00000000, mk(32'h7FC00000, 0, 0, 1), 1'b0);
    issue(32'h7F600000, 32'hC0000000, mk(32'hFF800000, 1, 0, 0), 1'b0);
    issue(32'hFF7FFFFF, 32'h00FFFFFF, ref_mul(32'hFF7FFFFF, 32'h00FFFFFF), 1'b0);
    issue(32'h00E00000, 32'h80800000, mk(32'h80000000, 0, 1, 0), 1'b0);
    issue(32'h80600003, 32'h80600003, mk(32'h00000000, 0, 0, 0), 1'b0);
    issue(32'hFF800000, 32'h3F800000, mk(32'hFF800000, 0, 0, 0), 1'b0);
    issue(32'h80000000, 32'h40000000, mk(32'h80000000, 0, 0, 0), 1'b0);

    // Reset in the middle of ITER: outputs clear, no done follows.
    n = 0;
    while (busy && n < 40) begin @(negedge clk); n++; end
    start = 1'b1; a = 32'h40400000; b = 32'h40400000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   {31'd0, busy}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_flags",  {29'd0, overflow, underflow, invalid}, 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("midrst_no_done", 32'(done_cnt), 32'd0);

    // Randomized operations, mostly back-to-back, some with gaps.
    for (int i = 0; i < 60; i++) begin
      x = gen_op();
      y = gen_op();
      issue(x, y, ref_mul(x, y), (i % 10) == 3);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
